// File: rtl/lc330_boot_loader_if.sv
// rtl/lc330_boot_loader_if.sv - byte stream, imem write port and CPU control bundle for the lc330 boot loader
interface lc330_boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err
   );
endinterface

// File: rtl/lc330_boot_loader.sv
// rtl/lc330_boot_loader.sv - loads a big-endian word stream into imem, then releases the lc330 CPU reset
module lc330_boot_loader #(
   parameter int ADDR_W      = 8,
   parameter int HOLD_CYCLES = 5
) (
   input logic                clk_i,
   input logic                rst_ni,
   lc330_boot_loader_if.slave ldr_if
);
   localparam int              HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
   localparam logic [32:0]     DEPTH_W   = 33'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_LOAD, S_HOLD, S_RUN, S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       asm_q, asm_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic [ADDR_W:0]   target_q, target_d;
   logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              ready;
   logic              xfer;
   logic              last_byte;
   logic [31:0]       word;

   assign ready     = (state_q == S_COUNT) || (state_q == S_LOAD);
   assign xfer      = ldr_if.in_valid && ready;
   assign last_byte = xfer && (byte_idx_q == 2'd3);
   assign word      = {asm_q, ldr_if.in_data};

   always_comb begin
      state_d     = state_q;
      byte_idx_d  = byte_idx_q;
      asm_d       = asm_q;
      remaining_d = remaining_q;
      target_d    = target_q;
      hold_cnt_d  = hold_cnt_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rst_d   = cpu_rst_q;
      done_d      = done_q;
      err_d       = err_q;

      // The shift register only has to hold the three leading bytes of a word.
      if (xfer) begin
         byte_idx_d = byte_idx_q + 2'd1;
         asm_d      = {asm_q[15:0], ldr_if.in_data};
      end

      case (state_q)
         S_IDLE: state_d = S_COUNT;
         S_COUNT: begin
            if (last_byte) begin
               if (word == 32'd0) begin
                  state_d    = S_HOLD;
                  hold_cnt_d = HOLD_INIT;
               end else if ({1'b0, word} > DEPTH_W) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d     = S_LOAD;
                  remaining_d = word[ADDR_W:0];
                  target_d    = '0;
               end
            end
         end
         S_LOAD: begin
            if (last_byte) begin
               we_d        = 1'b1;
               wdata_d     = word;
               addr_d      = target_q[ADDR_W-1:0];
               target_d    = target_q + CNT_ONE;
               remaining_d = remaining_q - CNT_ONE;
               if (remaining_q == CNT_ONE) begin
                  state_d    = S_HOLD;
                  hold_cnt_d = HOLD_INIT;
               end
            end
         end
         S_HOLD: begin
            hold_cnt_d = hold_cnt_q - HOLD_ONE;
            if (hold_cnt_q == HOLD_ONE) begin
               state_d   = S_RUN;
               cpu_rst_d = 1'b0;
               done_d    = 1'b1;
            end
         end
         S_RUN, S_ERR: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         byte_idx_q  <= 2'd0;
         asm_q       <= 24'd0;
         remaining_q <= '0;
         target_q    <= '0;
         hold_cnt_q  <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         cpu_rst_q   <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_idx_q  <= byte_idx_d;
         asm_q       <= asm_d;
         remaining_q <= remaining_d;
         target_q    <= target_d;
         hold_cnt_q  <= hold_cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rst_q   <= cpu_rst_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign ldr_if.in_ready   = ready;
   assign ldr_if.imem_we    = we_q;
   assign ldr_if.imem_addr  = addr_q;
   assign ldr_if.imem_wdata = wdata_q;
   assign ldr_if.cpu_rst    = cpu_rst_q;
   assign ldr_if.done       = done_q;
   assign ldr_if.err        = err_q;
endmodule
